// File: rtl/rvj1_wb_sram_bridge_pkg.sv
// Shared constants, FSM encoding and macro request payload for the Wishbone-to-SRAM bridge.
package rvj1_wb_sram_bridge_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SW   = 4;
  localparam int unsigned SRAM_AW = 9;

  localparam logic [31:0] BASE_ADDR_DEF   = 32'h3000_0000;
  localparam logic [31:0] IRAM_OFFSET_DEF = 32'h0000_0000;
  localparam logic [31:0] DRAM_OFFSET_DEF = 32'h0000_0800;
  localparam logic [31:0] WINDOW_BYTES    = 32'h0000_0800;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  typedef struct packed {
    logic               csb;
    logic               web;
    logic [WB_SW-1:0]   wmask;
    logic [SRAM_AW-1:0] addr;
    logic [WB_DW-1:0]   din;
  } sram_req_t;

  localparam sram_req_t SRAM_REQ_IDLE = '{csb: 1'b1, web: 1'b1, wmask: '0, addr: '0, din: '0};

  // Unsigned wrap makes addresses below base land far outside the window.
  function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base);
    logic [31:0] delta;
    delta = adr - base;
    return delta < WINDOW_BYTES;
  endfunction

endpackage

// File: rtl/rvj1_wb_addr_decode.sv
// Combinational decode of a Wishbone byte address into IRAM/DRAM/unmapped plus macro word address.
module rvj1_wb_addr_decode
  import rvj1_wb_sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = BASE_ADDR_DEF,
  parameter logic [31:0] IRAM_OFFSET      = IRAM_OFFSET_DEF,
  parameter logic [31:0] DRAM_OFFSET      = DRAM_OFFSET_DEF,
  parameter int unsigned ADDR_WIDTH_WORDS = SRAM_AW
) (
  input  logic [31:0]                 adr_i,
  output logic                        iram_hit_c_o,
  output logic                        dram_hit_c_o,
  output logic                        unmapped_c_o,
  output logic [ADDR_WIDTH_WORDS-1:0] word_adr_c_o
);

  localparam logic [31:0] IRAM_BASE = BASE_ADDR + IRAM_OFFSET;
  localparam logic [31:0] DRAM_BASE = BASE_ADDR + DRAM_OFFSET;

  // IRAM wins if a misconfiguration ever makes the windows overlap.
  always_comb begin
    iram_hit_c_o = in_window(adr_i, IRAM_BASE);
    dram_hit_c_o = in_window(adr_i, DRAM_BASE) && !iram_hit_c_o;
    unmapped_c_o = !(iram_hit_c_o || dram_hit_c_o);
    word_adr_c_o = adr_i[ADDR_WIDTH_WORDS+1:2];
  end

endmodule

// File: rtl/rvj1_wb_sram_bridge.sv
// Wishbone classic responder driving port 0 of the IRAM and DRAM OpenRAM macros.
module rvj1_wb_sram_bridge
  import rvj1_wb_sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = BASE_ADDR_DEF,
  parameter logic [31:0] IRAM_OFFSET      = IRAM_OFFSET_DEF,
  parameter logic [31:0] DRAM_OFFSET      = DRAM_OFFSET_DEF,
  parameter int unsigned ADDR_WIDTH_WORDS = SRAM_AW
) (
  input  logic                        wb_clk_i,
  input  logic                        rstn_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_dat_o,
  output logic                        iram_clk0,
  output logic                        iram_csb0,
  output logic                        iram_web0,
  output logic [3:0]                  iram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] iram_addr0,
  output logic [31:0]                 iram_din0,
  input  logic [31:0]                 iram_dout0,
  output logic                        dram_clk0,
  output logic                        dram_csb0,
  output logic                        dram_web0,
  output logic [3:0]                  dram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] dram_addr0,
  output logic [31:0]                 dram_din0,
  input  logic [31:0]                 dram_dout0,
  output logic                        err_o,
  output logic                        busy_o
);

  logic                        iram_hit_c;
  logic                        dram_hit_c;
  logic                        unmapped_c;
  logic [ADDR_WIDTH_WORDS-1:0] word_adr_c;

  state_e      state_q, state_d;
  sram_req_t   iram_q, iram_d;
  sram_req_t   dram_q, dram_d;
  sram_req_t   req_c;
  logic        tgt_dram_q, tgt_dram_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  rvj1_wb_addr_decode #(
    .BASE_ADDR       (BASE_ADDR),
    .IRAM_OFFSET     (IRAM_OFFSET),
    .DRAM_OFFSET     (DRAM_OFFSET),
    .ADDR_WIDTH_WORDS(ADDR_WIDTH_WORDS)
  ) u_decode (
    .adr_i       (wbs_adr_i),
    .iram_hit_c_o(iram_hit_c),
    .dram_hit_c_o(dram_hit_c),
    .unmapped_c_o(unmapped_c),
    .word_adr_c_o(word_adr_c)
  );

  always_ff @(posedge wb_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      iram_q     <= SRAM_REQ_IDLE;
      dram_q     <= SRAM_REQ_IDLE;
      tgt_dram_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iram_q     <= iram_d;
      dram_q     <= dram_d;
      tgt_dram_q <= tgt_dram_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Macro controls default to idle every cycle, so a request is asserted for exactly one clock.
  always_comb begin
    state_d    = state_q;
    iram_d     = SRAM_REQ_IDLE;
    dram_d     = SRAM_REQ_IDLE;
    req_c      = SRAM_REQ_IDLE;
    tgt_dram_d = tgt_dram_q;
    ack_d      = 1'b0;
    dat_d      = dat_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          if (unmapped_c) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            dat_d   = '0;
            err_d   = 1'b1;
          end else begin
            req_c.csb   = 1'b0;
            req_c.web   = !wbs_we_i;
            req_c.wmask = wbs_we_i ? wbs_sel_i : 4'h0;
            req_c.addr  = SRAM_AW'(word_adr_c);
            req_c.din   = wbs_we_i ? wbs_dat_i : 32'h0;
            tgt_dram_d  = dram_hit_c;
            if (dram_hit_c) dram_d = req_c;
            else if (iram_hit_c) iram_d = req_c;
            state_d = wbs_we_i ? ST_WR : ST_RD;
          end
        end
      end
      ST_WR: begin
        state_d = wbs_cyc_i ? ST_ACK : ST_IDLE;
        ack_d   = wbs_cyc_i;
      end
      ST_RD: begin
        state_d = wbs_cyc_i ? ST_RD_CAP : ST_IDLE;
      end
      ST_RD_CAP: begin
        if (wbs_cyc_i) begin
          dat_d   = tgt_dram_q ? dram_dout0 : iram_dout0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign iram_clk0   = wb_clk_i;
  assign dram_clk0   = wb_clk_i;
  assign iram_csb0   = iram_q.csb;
  assign iram_web0   = iram_q.web;
  assign iram_wmask0 = iram_q.wmask;
  assign iram_addr0  = ADDR_WIDTH_WORDS'(iram_q.addr);
  assign iram_din0   = iram_q.din;
  assign dram_csb0   = dram_q.csb;
  assign dram_web0   = dram_q.web;
  assign dram_wmask0 = dram_q.wmask;
  assign dram_addr0  = ADDR_WIDTH_WORDS'(dram_q.addr);
  assign dram_din0   = dram_q.din;
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rvj1_wb_sram_bridge.sv
// Directed table-driven bench for rvj1_wb_sram_bridge with behavioural 1rw macro models.
module tb_rvj1_wb_sram_bridge;

  logic        clk;
  logic        rstn;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        iram_clk0, iram_csb0, iram_web0;
  logic [3:0]  iram_wmask0;
  logic [8:0]  iram_addr0;
  logic [31:0] iram_din0, iram_dout0;
  logic        dram_clk0, dram_csb0, dram_web0;
  logic [3:0]  dram_wmask0;
  logic [8:0]  dram_addr0;
  logic [31:0] dram_din0, dram_dout0;
  logic        err, busy;

  int tests = 0;
  int fails = 0;

  rvj1_wb_sram_bridge dut (
    .wb_clk_i   (clk),
    .rstn_i     (rstn),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .iram_clk0  (iram_clk0),
    .iram_csb0  (iram_csb0),
    .iram_web0  (iram_web0),
    .iram_wmask0(iram_wmask0),
    .iram_addr0 (iram_addr0),
    .iram_din0  (iram_din0),
    .iram_dout0 (iram_dout0),
    .dram_clk0  (dram_clk0),
    .dram_csb0  (dram_csb0),
    .dram_web0  (dram_web0),
    .dram_wmask0(dram_wmask0),
    .dram_addr0 (dram_addr0),
    .dram_din0  (dram_din0),
    .dram_dout0 (dram_dout0),
    .err_o      (err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1rw macros: byte-masked write, registered read data.
  logic [31:0] iram_mem [512];
  logic [31:0] dram_mem [512];

  always @(posedge iram_clk0) begin
    if (!iram_csb0) begin
      if (!iram_web0) begin
        for (int b = 0; b < 4; b++)
          if (iram_wmask0[b]) iram_mem[iram_addr0][b*8 +: 8] <= iram_din0[b*8 +: 8];
      end else begin
        iram_dout0 <= iram_mem[iram_addr0];
      end
    end
  end

  always @(posedge dram_clk0) begin
    if (!dram_csb0) begin
      if (!dram_web0) begin
        for (int b = 0; b < 4; b++)
          if (dram_wmask0[b]) dram_mem[dram_addr0][b*8 +: 8] <= dram_din0[b*8 +: 8];
      end else begin
        dram_dout0 <= dram_mem[dram_addr0];
      end
    end
  end

  // Port activity monitor, sampled mid-cycle.
  int          iram_cnt = 0, dram_cnt = 0, excl_err = 0;
  logic [8:0]  mon_addr;
  logic        mon_web;
  logic [3:0]  mon_wmask;
  logic [31:0] mon_din;

  always @(negedge clk) begin
    if (!iram_csb0 && !dram_csb0) excl_err++;
    if (!iram_csb0) begin
      iram_cnt++;
      mon_addr = iram_addr0; mon_web = iram_web0; mon_wmask = iram_wmask0; mon_din = iram_din0;
    end
    if (!dram_csb0) begin
      dram_cnt++;
      mon_addr = dram_addr0; mon_web = dram_web0; mon_wmask = dram_wmask0; mon_din = dram_din0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One Wishbone classic access; lat counts edges from stb sampling until ack is seen.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat = n; break; end
    end
    rd  = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdat;
    bit          err;
    bit          mapped;
    bit          tgt_dram;
    logic [8:0]  waddr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int          lat, i0, d0;
    logic [31:0] rd;
    bit          saw_ack;
    int          busy_low_at;

    vecs[0]  = '{1'b1, 32'h3000_0010, 32'hCAFE_BABE, 4'hF, 2, 32'h0,         1'b0, 1'b1, 1'b0, 9'd4};
    vecs[1]  = '{1'b0, 32'h3000_0010, 32'h0,         4'h0, 3, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b0, 9'd4};
    vecs[2]  = '{1'b1, 32'h3000_0804, 32'hAABB_CCDD, 4'hF, 2, 32'h0,         1'b0, 1'b1, 1'b1, 9'd1};
    vecs[3]  = '{1'b1, 32'h3000_0804, 32'h1122_3344, 4'h4, 2, 32'h0,         1'b0, 1'b1, 1'b1, 9'd1};
    vecs[4]  = '{1'b0, 32'h3000_0805, 32'h0,         4'h1, 3, 32'hAA22_CCDD, 1'b0, 1'b1, 1'b1, 9'd1};
    vecs[5]  = '{1'b1, 32'h3000_0804, 32'h5555_5555, 4'h0, 2, 32'h0,         1'b0, 1'b1, 1'b1, 9'd1};
    vecs[6]  = '{1'b0, 32'h3000_0804, 32'h0,         4'hF, 3, 32'hAA22_CCDD, 1'b0, 1'b1, 1'b1, 9'd1};
    vecs[7]  = '{1'b0, 32'h3000_1000, 32'h0,         4'hF, 1, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0};
    vecs[8]  = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 3, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b0, 9'd4};
    vecs[9]  = '{1'b1, 32'h3000_07FC, 32'h1234_5678, 4'hF, 2, 32'h0,         1'b1, 1'b1, 1'b0, 9'd511};
    vecs[10] = '{1'b0, 32'h3000_07FC, 32'h0,         4'hF, 3, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 9'd511};
    vecs[11] = '{1'b0, 32'h2FFF_FFFC, 32'h0,         4'hF, 1, 32'h0,         1'b1, 1'b0, 1'b0, 9'd0};
    vecs[12] = '{1'b1, 32'h3000_0FFC, 32'hDEAD_BEEF, 4'hF, 2, 32'h0,         1'b1, 1'b1, 1'b1, 9'd511};
    vecs[13] = '{1'b0, 32'h3000_0FFC, 32'h0,         4'hF, 3, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 9'd511};

    rstn = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    #22;
    chk("rst_iram_csb", 32'(iram_csb0), 32'h1);
    chk("rst_dram_csb", 32'(dram_csb0), 32'h1);
    chk("rst_web",      32'({iram_web0, dram_web0}), 32'h3);
    chk("rst_wmask",    32'({iram_wmask0, dram_wmask0}), 32'h0);
    chk("rst_addr_din", 32'(iram_addr0) | 32'(dram_addr0) | iram_din0 | dram_din0, 32'h0);
    chk("rst_ack",      32'(ack), 32'h0);
    chk("rst_dat",      rdat, 32'h0);
    chk("rst_err",      32'(err), 32'h0);
    chk("rst_busy",     32'(busy), 32'h0);
    @(negedge clk); rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      i0 = iram_cnt; d0 = dram_cnt;
      wb_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel, lat, rd);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
      if (!vecs[i].we) chk($sformatf("v%0d_rdat", i), rd, vecs[i].rdat);
      chk($sformatf("v%0d_iram_cycles", i), 32'(iram_cnt - i0),
          32'(vecs[i].mapped && !vecs[i].tgt_dram));
      chk($sformatf("v%0d_dram_cycles", i), 32'(dram_cnt - d0),
          32'(vecs[i].mapped && vecs[i].tgt_dram));
      if (vecs[i].mapped) begin
        chk($sformatf("v%0d_addr", i),  32'(mon_addr), 32'(vecs[i].waddr));
        chk($sformatf("v%0d_web", i),   32'(mon_web), 32'(!vecs[i].we));
        chk($sformatf("v%0d_wmask", i), 32'(mon_wmask), vecs[i].we ? 32'(vecs[i].sel) : 32'h0);
        chk($sformatf("v%0d_din", i),   mon_din, vecs[i].we ? vecs[i].wdat : 32'h0);
      end
    end

    // cyc dropped during RD: no ack, bridge goes idle, next write is served normally.
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    saw_ack = 1'b0; busy_low_at = 99;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      if (ack) saw_ack = 1'b1;
      if (!busy && busy_low_at == 99) busy_low_at = n;
    end
    chk("abort_no_ack", 32'(saw_ack), 32'h0);
    chk("abort_busy_fall", 32'(busy_low_at <= 2), 32'h1);
    wb_access(1'b1, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, lat, rd);
    chk("abort_next_wr_lat", 32'(lat), 32'h2);
    wb_access(1'b0, 32'h3000_0000, 32'h0, 4'hF, lat, rd);
    chk("abort_next_rd_dat", rd, 32'h0BAD_F00D);

    // Async reset while in RD_CAP.
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rcap_busy_pre", 32'(busy), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("rcap_rst_csb", 32'({iram_csb0, dram_csb0}), 32'h3);
    chk("rcap_rst_ack", 32'(ack), 32'h0);
    chk("rcap_rst_dat", rdat, 32'h0);
    chk("rcap_rst_err", 32'(err), 32'h0);
    chk("rcap_rst_busy", 32'(busy), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk("rcap_idle_after", 32'(busy), 32'h0);
    wb_access(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, rd);
    chk("rcap_post_lat", 32'(lat), 32'h3);
    chk("rcap_post_dat", rd, 32'hCAFE_BABE);
    chk("rcap_post_err", 32'(err), 32'h0);

    chk("csb_exclusive", 32'(excl_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
